// File: rtl/raster_tile_scheduler.sv
// Batches triangle bounding boxes, then walks every tile of the screen in raster order,
// issuing one raster job per overlapping triangle and one flush per tile.
//
//   state | meaning
//   LOAD  | accept triangle descriptors into batch slots
//   SCAN  | test slot idx against the current tile, one slot per cycle
//   ISSUE | job_vld held until job_rdy
//   FLUSH | flush_vld held until flush_rdy, then advance tile
//   DONE  | one-cycle frame_done pulse, then back to LOAD
module raster_tile_scheduler #(
  parameter int MAX_TRIS  = 8,
  parameter int TILE_COLS = 40,
  parameter int TILE_ROWS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tri_vld,
  output logic       tri_rdy,
  input  logic [4:0] tri_tx_min,
  input  logic [4:0] tri_tx_max,
  input  logic [3:0] tri_ty_min,
  input  logic [3:0] tri_ty_max,
  input  logic [3:0] tri_color,
  input  logic       tri_last,
  output logic       job_vld,
  input  logic       job_rdy,
  output logic [4:0] job_tile_x,
  output logic [3:0] job_tile_y,
  output logic [2:0] job_tri_idx,
  output logic [3:0] job_color,
  output logic       flush_vld,
  input  logic       flush_rdy,
  output logic [4:0] flush_tile_x,
  output logic [3:0] flush_tile_y,
  output logic [3:0] flush_count,
  output logic       frame_done,
  output logic       busy
);

  // The tile walk needs more range than the 5/4-bit coordinate ports carry
  // (40x30 by default); ports report the low bits of the tile counters.
  localparam int XW = ($clog2(TILE_COLS) > 5) ? $clog2(TILE_COLS) : 5;
  localparam int YW = ($clog2(TILE_ROWS) > 4) ? $clog2(TILE_ROWS) : 4;
  localparam logic [XW-1:0] LAST_X  = XW'(TILE_COLS - 1);
  localparam logic [YW-1:0] LAST_Y  = YW'(TILE_ROWS - 1);
  localparam logic [3:0]    MAX_CNT = 4'(MAX_TRIS);

  typedef enum logic [2:0] {LOAD, SCAN, ISSUE, FLUSH, DONE} state_t;

  state_t state, next_state;

  logic [4:0] slot_tx_min [MAX_TRIS];
  logic [4:0] slot_tx_max [MAX_TRIS];
  logic [3:0] slot_ty_min [MAX_TRIS];
  logic [3:0] slot_ty_max [MAX_TRIS];
  logic [3:0] slot_color  [MAX_TRIS];

  logic [3:0]    count, count_d;
  logic [2:0]    idx, idx_d;
  logic [XW-1:0] tile_x, tile_x_d;
  logic [YW-1:0] tile_y, tile_y_d;
  logic [3:0]    jcnt, jcnt_d;

  logic accept, overlap, last_slot, last_tile;

  logic       tri_rdy_d, job_vld_d, flush_vld_d, frame_done_d, busy_d;
  logic [4:0] job_tile_x_d, flush_tile_x_d;
  logic [3:0] job_tile_y_d, flush_tile_y_d;
  logic [2:0] job_tri_idx_d;
  logic [3:0] job_color_d, flush_count_d;

  assign accept    = (state == LOAD) && tri_vld && tri_rdy;
  // An inverted box (min > max) fails one of the two compares, so it never overlaps.
  assign overlap   = (XW'(slot_tx_min[idx]) <= tile_x) && (tile_x <= XW'(slot_tx_max[idx])) &&
                     (YW'(slot_ty_min[idx]) <= tile_y) && (tile_y <= YW'(slot_ty_max[idx]));
  assign last_slot = ({1'b0, idx} == (count - 4'd1));
  assign last_tile = (tile_x == LAST_X) && (tile_y == LAST_Y);

  always_ff @(posedge clk) begin
    if (accept) begin
      slot_tx_min[count[2:0]] <= tri_tx_min;
      slot_tx_max[count[2:0]] <= tri_tx_max;
      slot_ty_min[count[2:0]] <= tri_ty_min;
      slot_ty_max[count[2:0]] <= tri_ty_max;
      slot_color[count[2:0]]  <= tri_color;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= LOAD;
      count  <= '0;
      idx    <= '0;
      tile_x <= '0;
      tile_y <= '0;
      jcnt   <= '0;
    end else begin
      state  <= next_state;
      count  <= count_d;
      idx    <= idx_d;
      tile_x <= tile_x_d;
      tile_y <= tile_y_d;
      jcnt   <= jcnt_d;
    end
  end

  always_comb begin
    next_state = state;
    count_d    = count;
    idx_d      = idx;
    tile_x_d   = tile_x;
    tile_y_d   = tile_y;
    jcnt_d     = jcnt;
    unique case (state)
      LOAD: begin
        if (accept) begin
          count_d = count + 4'd1;
          if (tri_last || (count + 4'd1 == MAX_CNT)) begin
            next_state = SCAN;
            idx_d      = '0;
            tile_x_d   = '0;
            tile_y_d   = '0;
            jcnt_d     = '0;
          end
        end
      end
      SCAN: begin
        if (overlap)        next_state = ISSUE;
        else if (last_slot) next_state = FLUSH;
        else                idx_d = idx + 3'd1;
      end
      ISSUE: begin
        if (job_rdy) begin
          jcnt_d = jcnt + 4'd1;
          if (last_slot) begin
            next_state = FLUSH;
          end else begin
            next_state = SCAN;
            idx_d      = idx + 3'd1;
          end
        end
      end
      FLUSH: begin
        if (flush_rdy) begin
          idx_d  = '0;
          jcnt_d = '0;
          if (last_tile) begin
            next_state = DONE;
            tile_x_d   = '0;
            tile_y_d   = '0;
          end else begin
            next_state = SCAN;
            if (tile_x == LAST_X) begin
              tile_x_d = '0;
              tile_y_d = tile_y + YW'(1);
            end else begin
              tile_x_d = tile_x + XW'(1);
            end
          end
        end
      end
      DONE: begin
        next_state = LOAD;
        count_d    = '0;
      end
      default: next_state = LOAD;
    endcase
  end

  // Output values are computed from the next state so the registered outputs line up with it.
  always_comb begin
    tri_rdy_d      = (next_state == LOAD) && (count_d < MAX_CNT);
    job_vld_d      = (next_state == ISSUE);
    flush_vld_d    = (next_state == FLUSH);
    frame_done_d   = (next_state == DONE);
    busy_d         = (next_state != LOAD);
    job_tile_x_d   = job_tile_x;
    job_tile_y_d   = job_tile_y;
    job_tri_idx_d  = job_tri_idx;
    job_color_d    = job_color;
    flush_tile_x_d = flush_tile_x;
    flush_tile_y_d = flush_tile_y;
    flush_count_d  = flush_count;
    if ((state == SCAN) && overlap) begin
      job_tile_x_d  = tile_x[4:0];
      job_tile_y_d  = tile_y[3:0];
      job_tri_idx_d = idx;
      job_color_d   = slot_color[idx];
    end
    if ((next_state == FLUSH) && (state != FLUSH)) begin
      flush_tile_x_d = tile_x[4:0];
      flush_tile_y_d = tile_y[3:0];
      flush_count_d  = jcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tri_rdy      <= 1'b1;
      job_vld      <= 1'b0;
      flush_vld    <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      job_tile_x   <= '0;
      job_tile_y   <= '0;
      job_tri_idx  <= '0;
      job_color    <= '0;
      flush_tile_x <= '0;
      flush_tile_y <= '0;
      flush_count  <= '0;
    end else begin
      tri_rdy      <= tri_rdy_d;
      job_vld      <= job_vld_d;
      flush_vld    <= flush_vld_d;
      frame_done   <= frame_done_d;
      busy         <= busy_d;
      job_tile_x   <= job_tile_x_d;
      job_tile_y   <= job_tile_y_d;
      job_tri_idx  <= job_tri_idx_d;
      job_color    <= job_color_d;
      flush_tile_x <= flush_tile_x_d;
      flush_tile_y <= flush_tile_y_d;
      flush_count  <= flush_count_d;
    end
  end

endmodule

// File: tb/tb_raster_tile_scheduler.sv
// Scoreboard bench: a reference walk of all tiles predicts every job and flush in order.
module tb_raster_tile_scheduler;
  localparam int COLS = 40;
  localparam int ROWS = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tri_vld, tri_rdy, tri_last;
  logic [4:0] tri_tx_min, tri_tx_max;
  logic [3:0] tri_ty_min, tri_ty_max, tri_color;
  logic       job_vld, job_rdy;
  logic [4:0] job_tile_x;
  logic [3:0] job_tile_y;
  logic [2:0] job_tri_idx;
  logic [3:0] job_color;
  logic       flush_vld, flush_rdy;
  logic [4:0] flush_tile_x;
  logic [3:0] flush_tile_y, flush_count;
  logic       frame_done, busy;

  always #5 clk = ~clk;

  raster_tile_scheduler #(.MAX_TRIS(8), .TILE_COLS(COLS), .TILE_ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n),
    .tri_vld(tri_vld), .tri_rdy(tri_rdy),
    .tri_tx_min(tri_tx_min), .tri_tx_max(tri_tx_max),
    .tri_ty_min(tri_ty_min), .tri_ty_max(tri_ty_max),
    .tri_color(tri_color), .tri_last(tri_last),
    .job_vld(job_vld), .job_rdy(job_rdy),
    .job_tile_x(job_tile_x), .job_tile_y(job_tile_y),
    .job_tri_idx(job_tri_idx), .job_color(job_color),
    .flush_vld(flush_vld), .flush_rdy(flush_rdy),
    .flush_tile_x(flush_tile_x), .flush_tile_y(flush_tile_y), .flush_count(flush_count),
    .frame_done(frame_done), .busy(busy)
  );

  typedef struct {bit is_flush; int x; int y; int a; int color;} ev_t;
  ev_t exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int m_n = 0;
  int m_txmin[8], m_txmax[8], m_tymin[8], m_tymax[8], m_color[8];

  task automatic send_tri(input int txmin, input int txmax, input int tymin, input int tymax,
                          input int color, input bit last);
    int w = 0;
    m_txmin[m_n] = txmin; m_txmax[m_n] = txmax;
    m_tymin[m_n] = tymin; m_tymax[m_n] = tymax;
    m_color[m_n] = color; m_n++;
    tri_tx_min = 5'(txmin); tri_tx_max = 5'(txmax);
    tri_ty_min = 4'(tymin); tri_ty_max = 4'(tymax);
    tri_color  = 4'(color); tri_last   = last; tri_vld = 1'b1;
    while (!tri_rdy && w < 50) begin @(negedge clk); w++; end
    n_assert++;
    if (tri_rdy !== 1'b1) begin
      n_fail++; $display("FAIL tri_accept: tri_rdy=%b required 1", tri_rdy);
    end
    @(negedge clk);
    tri_vld = 1'b0; tri_last = 1'b0;
  endtask

  task automatic build_expected();
    exp_q.delete();
    for (int ty = 0; ty < ROWS; ty++)
      for (int tx = 0; tx < COLS; tx++) begin
        int cnt = 0;
        for (int i = 0; i < m_n; i++)
          if (m_txmin[i] <= tx && tx <= m_txmax[i] && m_tymin[i] <= ty && ty <= m_tymax[i]) begin
            exp_q.push_back('{1'b0, tx & 31, ty & 15, i, m_color[i]});
            cnt++;
          end
        exp_q.push_back('{1'b1, tx & 31, ty & 15, cnt, 0});
      end
  endtask

  // Consumes a frame already loaded into the DUT; stall holds job_rdy low on the first job.
  task automatic run_frame(input string name, input int exp_jobs, input int stall);
    int jobs = 0, flushes = 0, cyc = 0, stall_left = stall;
    bit done = 0, snap_ok = 0;
    logic [4:0] sx; logic [3:0] sy, sc; logic [2:0] si;
    ev_t e;
    build_expected();
    job_rdy = 1'b1; flush_rdy = 1'b1;
    while (!done && cyc < 30000) begin
      if (job_vld && flush_vld) begin
        n_assert++; n_fail++;
        $display("FAIL %s exclusive: job_vld=1 flush_vld=1 required not both", name);
      end
      if (job_vld && stall_left > 0) begin
        if (!snap_ok) begin
          sx = job_tile_x; sy = job_tile_y; si = job_tri_idx; sc = job_color; snap_ok = 1;
        end else begin
          n_assert++;
          if (job_tile_x !== sx || job_tile_y !== sy || job_tri_idx !== si || job_color !== sc ||
              flush_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL %s stall_stable: got (%0d,%0d) idx%0d col%0d flush_vld=%b required (%0d,%0d) idx%0d col%0d flush_vld=0",
                     name, job_tile_x, job_tile_y, job_tri_idx, job_color, flush_vld, sx, sy, si, sc);
          end
        end
        job_rdy = 1'b0; stall_left--;
      end else if (job_vld) begin
        job_rdy = 1'b1; jobs++;
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s job: unexpected job (%0d,%0d) idx%0d", name, job_tile_x, job_tile_y, job_tri_idx);
        end else begin
          e = exp_q.pop_front();
          if (e.is_flush || job_tile_x !== 5'(e.x) || job_tile_y !== 4'(e.y) ||
              job_tri_idx !== 3'(e.a) || job_color !== 4'(e.color)) begin
            n_fail++;
            $display("FAIL %s job: got job (%0d,%0d) idx%0d col%0d required %s (%0d,%0d) a%0d col%0d",
                     name, job_tile_x, job_tile_y, job_tri_idx, job_color,
                     e.is_flush ? "flush" : "job", e.x, e.y, e.a, e.color);
          end
        end
      end else begin
        job_rdy = 1'b1;
      end
      if (flush_vld) begin
        flushes++;
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s flush: unexpected flush (%0d,%0d)", name, flush_tile_x, flush_tile_y);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_flush || flush_tile_x !== 5'(e.x) || flush_tile_y !== 4'(e.y) ||
              flush_count !== 4'(e.a)) begin
            n_fail++;
            $display("FAIL %s flush: got flush (%0d,%0d) cnt%0d required %s (%0d,%0d) a%0d",
                     name, flush_tile_x, flush_tile_y, flush_count,
                     e.is_flush ? "flush" : "job", e.x, e.y, e.a);
          end
        end
      end
      if (frame_done) done = 1;
      @(negedge clk);
      cyc++;
    end
    n_assert++;
    if (!done) begin
      n_fail++; $display("FAIL %s frame_done: not seen within %0d cycles, required 1 pulse", name, cyc);
    end
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL %s leftover: %0d expected events not produced, required 0", name, exp_q.size());
    end
    n_assert++;
    if (jobs != exp_jobs || flushes != COLS * ROWS) begin
      n_fail++; $display("FAIL %s totals: jobs=%0d flushes=%0d required jobs=%0d flushes=%0d",
                         name, jobs, flushes, exp_jobs, COLS * ROWS);
    end
    n_assert++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || tri_rdy !== 1'b1) begin
      n_fail++; $display("FAIL %s after_done: frame_done=%b busy=%b tri_rdy=%b required 0 0 1",
                         name, frame_done, busy, tri_rdy);
    end
    m_n = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tri_vld = 1'b0; tri_last = 1'b0; job_rdy = 1'b1; flush_rdy = 1'b1;
    tri_tx_min = '0; tri_tx_max = '0; tri_ty_min = '0; tri_ty_max = '0; tri_color = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_assert++;
    if (job_vld !== 1'b0 || flush_vld !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 ||
        tri_rdy !== 1'b1) begin
      n_fail++; $display("FAIL reset_ctrl: job_vld=%b flush_vld=%b frame_done=%b busy=%b tri_rdy=%b required 0 0 0 0 1",
                         job_vld, flush_vld, frame_done, busy, tri_rdy);
    end
    n_assert++;
    if (job_tile_x !== 0 || job_tile_y !== 0 || job_tri_idx !== 0 || job_color !== 0 ||
        flush_tile_x !== 0 || flush_tile_y !== 0 || flush_count !== 0) begin
      n_fail++; $display("FAIL reset_fields: job (%0d,%0d,%0d,%0d) flush (%0d,%0d,%0d) required all 0",
                         job_tile_x, job_tile_y, job_tri_idx, job_color, flush_tile_x, flush_tile_y, flush_count);
    end
  endtask

  task automatic test_single();
    send_tri(0, 0, 0, 0, 5, 1'b1);
    run_frame("single", 1, 0);
  endtask

  task automatic test_two_overlap();
    send_tri(3, 3, 2, 2, 7, 1'b0);
    send_tri(3, 3, 2, 2, 12, 1'b1);
    run_frame("two_overlap", 2, 0);
  endtask

  task automatic test_stall();
    send_tri(1, 1, 0, 0, 9, 1'b1);
    run_frame("stall", 1, 5);
  endtask

  task automatic test_inverted();
    send_tri(5, 4, 0, 3, 3, 1'b1);
    run_frame("inverted", 0, 0);
  endtask

  task automatic test_full_batch();
    int tb [8][4] = '{'{0,1,0,0}, '{2,2,0,1}, '{5,4,0,0}, '{31,31,14,15},
                      '{0,0,0,0}, '{10,12,3,3}, '{3,3,2,2}, '{7,6,1,1}};
    for (int i = 0; i < 8; i++)
      send_tri(tb[i][0], tb[i][1], tb[i][2], tb[i][3], int'($urandom_range(15)), 1'b0);
    n_assert++;
    if (tri_rdy !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL full_batch_rdy: tri_rdy=%b busy=%b required 0 1", tri_rdy, busy);
    end
    run_frame("full_batch", 11, 0);
  endtask

  task automatic test_reset_mid();
    int w = 0;
    job_rdy = 1'b0; flush_rdy = 1'b1;
    send_tri(2, 2, 1, 1, 6, 1'b1);
    while (!job_vld && w < 500) begin @(negedge clk); w++; end
    n_assert++;
    if (job_vld !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_issue: job_vld=%b required 1", job_vld);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_assert++;
    if (job_vld !== 1'b0 || busy !== 1'b0 || tri_rdy !== 1'b1 || flush_vld !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_state: job_vld=%b busy=%b tri_rdy=%b flush_vld=%b required 0 0 1 0",
                         job_vld, busy, tri_rdy, flush_vld);
    end
    job_rdy = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++;
    if (job_vld !== 1'b0 || flush_vld !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_idle: job_vld=%b flush_vld=%b busy=%b required 0 0 0",
                         job_vld, flush_vld, busy);
    end
    m_n = 0;
    send_tri(4, 4, 3, 3, 2, 1'b1);
    run_frame("after_reset", 1, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_overlap();
    test_stall();
    test_inverted();
    test_full_batch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
